nand_gate_checker: RTL and testbench
====================================

Name: nand_gate_checker

Overview:
Hardware stimulus/response engine for the two-input NAND cell: the driving end of the A/B/Y interface that the standalone nand_gate bench exercises from simulation. On start, it walks {A,B} through 00, 01, 10, 11, waits a settle window per vector, samples Y, and compares it against ~(A&B). It accumulates per-vector failure flags and an error count, then reports pass/fail. Used for on-chip self-test of gate cells and as a reusable checker in gate-level benches.

Parameters:
SETTLE_CYCLES, 2, clock cycles A/B are held before Y is sampled (legal range >=1)
N_PASSES, 1, number of full 4-vector sweeps per start (legal range >=1)
ERR_W, 8, width of err_count

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
start  input  1  begin a test run; honoured only in IDLE
y_i  input  1  Y output of the gate under test
a_o  output  1  A drive to the gate under test (registered)
b_o  output  1  B drive to the gate under test (registered)
busy  output  1  high while a run is in progress
done  output  1  one-cycle pulse when a run completes
pass  output  1  1 = last run had zero mismatches; held until next start
err_count  output  ERR_W  mismatches in the last run; saturating
fail_vec  output  4  sticky per-vector fail flags; bit i = vector {A,B}=i

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-high on rst. Asserting rst forces state IDLE and all outputs, counters, vector index and pass counter to 0 immediately, including mid-run. No partial result survives.
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE: busy=0. When start=1, the block loads idx=0, pass_cnt=0 and settle_cnt=0. It drives a_o/b_o=00, clears err_count, fail_vec and pass, and goes to SETTLE.
- SETTLE: busy=1. settle_cnt increments each cycle. When settle_cnt==SETTLE_CYCLES-1, the next state is SAMPLE.
- SAMPLE: busy=1. The block compares y_i against ~(a_o&b_o), using case inequality so that X/Z on y_i counts as a mismatch.
  - On mismatch: err_count increments, saturating at 2^ERR_W-1, and fail_vec[idx] is set.
  - If idx==3 and pass_cnt==N_PASSES-1, the next state is DONE.
  - Otherwise idx increments modulo 4 and pass_cnt increments when idx wraps 3->0. a_o/b_o take the new idx bits ({a_o,b_o}=idx), settle_cnt is set to 0, and the next state is SETTLE.
- DONE: busy=0 and done=1 for exactly this cycle. pass is registered as (err_count==0), using the value that includes the final sample. The next state is IDLE.
- Timing:
  - Each vector occupies SETTLE_CYCLES+1 cycles.
  - From the start-accept edge to the done pulse takes 4*N_PASSES*(SETTLE_CYCLES+1) cycles. With default parameters this is 12 cycles; done is high in cycle 13.
- a_o/b_o hold their value across SETTLE and SAMPLE. They change only on the SAMPLE->SETTLE transition. After the run they keep 11 until the next start.
- start asserted during SETTLE, SAMPLE or DONE is ignored and is not queued. start held high continuously re-triggers a run on the first IDLE cycle after DONE.
- Sampling happens only in SAMPLE. Changes on y_i during SETTLE have no effect.
- err_count, fail_vec and pass are stable from the done pulse until the next accepted start.

Optional Feature:
NAND_CHECK_STOP_ON_FAIL_EN
- Defined: on the first mismatch in SAMPLE, the FSM goes straight to DONE after the counters update. fail_vec has exactly one bit set, err_count=1 and pass=0. a_o/b_o hold the failing vector for debug.
- Undefined: the run always completes all 4*N_PASSES vectors, as described above.

Test Plan:
1. Ideal NAND model on y_i, defaults, start pulsed once -> a_o/b_o sequence 00,01,10,11, each held 3 cycles; done pulses 12 cycles after accept; pass=1, err_count=0, fail_vec=0000.
2. y_i stuck at 1 -> vector 11 mismatches; pass=0, err_count=1, fail_vec=1000.
3. y_i = A&B (inverted gate), N_PASSES=3 -> err_count=12, fail_vec=1111, pass=0; done pulses after 36 cycles.
4. rst asserted at cycle 5 of a run -> busy, a_o, b_o, err_count and fail_vec go to 0 asynchronously; a new start yields a clean full run with pass=1.
5. start pulsed again during SETTLE and during DONE -> ignored. Only one done pulse, and the results match a single run.
6. NAND_CHECK_STOP_ON_FAIL_EN defined, y_i stuck at 0 -> done pulses 3 cycles after accept; fail_vec=0001, err_count=1, a_o/b_o=00.

Source files
------------

// File: rtl/nand_gate_checker.sv
// Stimulus/response checker for a two-input NAND cell: sweeps {A,B} = 00..11, samples Y after a settle window.
// Optional build macro NAND_CHECK_STOP_ON_FAIL_EN ends the run on the first mismatch.
module nand_gate_checker #(
  parameter int SETTLE_CYCLES = 2,
  parameter int N_PASSES      = 1,
  parameter int ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             y_i,
  output logic             a_o,
  output logic             b_o,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [3:0]       fail_vec
);

  localparam int SCW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int PCW = (N_PASSES > 1) ? $clog2(N_PASSES) : 1;

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  state_t         state, state_nxt;
  logic [SCW-1:0] settle_cnt;
  logic [PCW-1:0] pass_cnt;
  logic [1:0]     idx;
  logic           mismatch;
  logic           last_vec;
  logic           settle_last;
  logic           finish;

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Case inequality so an X/Z response from the gate is never mistaken for a match
  assign mismatch    = (y_i !== ~(a_o & b_o));
  assign last_vec    = (idx == 2'd3) && (pass_cnt == PCW'(N_PASSES - 1));
  assign settle_last = (settle_cnt == SCW'(SETTLE_CYCLES - 1));

  assign busy = (state == SETTLE) || (state == SAMPLE);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    finish    = 1'b0;
    case (state)
      IDLE:   if (start) state_nxt = SETTLE;
      SETTLE: if (settle_last) state_nxt = SAMPLE;
      SAMPLE: begin
`ifdef NAND_CHECK_STOP_ON_FAIL_EN
        finish = last_vec || mismatch;
`else
        finish = last_vec;
`endif
        state_nxt = finish ? DONE : SETTLE;
      end
      DONE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx        <= '0;
      pass_cnt   <= '0;
      settle_cnt <= '0;
      a_o        <= 1'b0;
      b_o        <= 1'b0;
      err_count  <= '0;
      fail_vec   <= '0;
      pass       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            idx        <= '0;
            pass_cnt   <= '0;
            settle_cnt <= '0;
            a_o        <= 1'b0;
            b_o        <= 1'b0;
            err_count  <= '0;
            fail_vec   <= '0;
            pass       <= 1'b0;
          end
        end
        SETTLE: settle_cnt <= settle_cnt + 1'b1;
        SAMPLE: begin
          if (mismatch) begin
            err_count     <= sat_inc(err_count);
            fail_vec[idx] <= 1'b1;
          end
          // pass reflects the count including this final sample; a saturating increment never yields 0
          if (finish) begin
            pass <= !mismatch && (err_count == '0);
          end else begin
            idx          <= idx + 2'd1;
            {a_o, b_o}   <= idx + 2'd1;
            settle_cnt   <= '0;
            if (idx == 2'd3) pass_cnt <= pass_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nand_gate_checker.sv
// Randomized self-checking bench for nand_gate_checker: a faulty-gate model drives y_i, results checked against a closed-form run model.
module tb_nand_gate_checker;

  localparam int S  = 2;
  localparam int P1 = 1;
  localparam int P3 = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] mask;

  logic       a1, b1, y1, busy1, done1, pass1;
  logic [7:0] err1;
  logic [3:0] fv1;
  logic       a3, b3, y3, busy3, done3, pass3;
  logic [7:0] err3;
  logic [3:0] fv3;

  int n_cmp = 0;
  int n_bad = 0;

  // Gate under test: ideal NAND with the vectors selected by mask flipped
  assign y1 = ~(a1 & b1) ^ mask[{a1, b1}];
  assign y3 = ~(a3 & b3) ^ mask[{a3, b3}];

  always #5 clk = ~clk;

  nand_gate_checker #(.SETTLE_CYCLES(S), .N_PASSES(P1), .ERR_W(8)) dut1 (
    .clk(clk), .rst(rst), .start(start), .y_i(y1), .a_o(a1), .b_o(b1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .fail_vec(fv1)
  );

  nand_gate_checker #(.SETTLE_CYCLES(S), .N_PASSES(P3), .ERR_W(8)) dut3 (
    .clk(clk), .rst(rst), .start(start), .y_i(y3), .a_o(a3), .b_o(b3),
    .busy(busy3), .done(done3), .pass(pass3), .err_count(err3), .fail_vec(fv3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void expect_run(input int np, input logic [3:0] m, output int lat,
                                     output int err, output logic [3:0] fv,
                                     output logic ps, output logic [1:0] ab);
    lat = 4 * np * (S + 1);
    err = np * $countones(m);
    if (err > 255) err = 255;
    fv = m;
    ps = (m == 4'd0);
    ab = 2'b11;
`ifdef NAND_CHECK_STOP_ON_FAIL_EN
    if (m != 4'd0) begin
      for (int k = 3; k >= 0; k--) begin
        if (m[k]) begin
          lat = (k + 1) * (S + 1);
          ab  = 2'(k);
          fv  = 4'(1 << k);
        end
      end
      err = 1;
      ps  = 1'b0;
    end
`endif
  endfunction

  task automatic check_results(input string name, input int e1, input logic [3:0] f1, input logic p1,
                               input int e3, input logic [3:0] f3, input logic p3);
    chk({name, ":err1"},  32'(err1),  32'(e1));
    chk({name, ":fv1"},   32'(fv1),   32'(f1));
    chk({name, ":pass1"}, 32'(pass1), 32'(p1));
    chk({name, ":err3"},  32'(err3),  32'(e3));
    chk({name, ":fv3"},   32'(fv3),   32'(f3));
    chk({name, ":pass3"}, 32'(pass3), 32'(p3));
  endtask

  // Called #1 after a rising edge with both checkers idle
  task automatic run(input logic [3:0] m, input bit extra, input string name);
    int lat1, lat3, e1, e3, vec;
    logic [3:0] f1, f3;
    logic p1, p3;
    logic [1:0] ab1, ab3;
    expect_run(P1, m, lat1, e1, f1, p1, ab1);
    expect_run(P3, m, lat3, e3, f3, p3, ab3);
    mask  = m;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= lat3 + 3; c++) begin
      if (c <= lat1) begin
        vec = ((c - 1) / (S + 1)) % 4;
        chk({name, ":busy1"}, 32'(busy1), 32'd1);
        chk({name, ":ab1"},   32'({a1, b1}), 32'(vec));
        chk({name, ":done1_early"}, 32'(done1), 32'd0);
      end else if (c == lat1 + 1) begin
        chk({name, ":done1"}, 32'(done1), 32'd1);
        chk({name, ":busy1_done"}, 32'(busy1), 32'd0);
        chk({name, ":pass1_at_done"}, 32'(pass1), 32'(p1));
        chk({name, ":err1_at_done"},  32'(err1),  32'(e1));
        chk({name, ":fv1_at_done"},   32'(fv1),   32'(f1));
      end else begin
        chk({name, ":done1_extra"}, 32'(done1), 32'd0);
        chk({name, ":busy1_after"}, 32'(busy1), 32'd0);
      end
      if (c == lat3 + 1) chk({name, ":done3"}, 32'(done3), 32'd1);
      else               chk({name, ":done3_off"}, 32'(done3), 32'd0);
      start = (extra && (c == 2 || c == lat1 + 1)) ? 1'b1 : 1'b0;
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk({name, ":ab1_final"}, 32'({a1, b1}), 32'(ab1));
    chk({name, ":ab3_final"}, 32'({a3, b3}), 32'(ab3));
    check_results(name, e1, f1, p1, e3, f3, p3);
  endtask

  initial begin
    rst   = 1'b0;
    start = 1'b0;
    mask  = 4'd0;
    #2 rst = 1'b1;
    #2;
    chk("rst:busy", 32'(busy1), 32'd0);
    chk("rst:done", 32'(done1), 32'd0);
    chk("rst:ab",   32'({a1, b1}), 32'd0);
    check_results("rst", 0, 4'd0, 1'b0, 0, 4'd0, 1'b0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk); #1;

    run(4'h0, 1'b0, "ideal");
    run(4'h8, 1'b0, "stuck1");
    run(4'hF, 1'b0, "and_gate");
    run(4'h7, 1'b0, "stuck0");

    // Asynchronous reset in the middle of a faulty run
    mask  = 4'hF;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("mid:err_pre", 32'(err1), 32'd1);
    chk("mid:fv_pre",  32'(fv1),  32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid:busy1", 32'(busy1), 32'd0);
    chk("mid:busy3", 32'(busy3), 32'd0);
    chk("mid:ab1",   32'({a1, b1}), 32'd0);
    check_results("mid", 0, 4'd0, 1'b0, 0, 4'd0, 1'b0);
    @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    run(4'h0, 1'b0, "post_rst");

    run(4'h0, 1'b1, "restart_ign");
    run(4'h2, 1'b1, "restart_ign_f");

    for (int i = 0; i < 8; i++) begin
      run(4'($urandom_range(0, 15)), bit'($urandom_range(0, 1)), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
